// File: rtl/dynamixel_pkg.sv
// Shared definitions for Dynamixel Protocol 2.0 frame builders.
//   - fixed header bytes, broadcast ID, instruction codes
//   - sync-write FSM state and frame-phase enums
//   - crc16_update: one-byte step of CRC-16/BUYPASS (poly 0x8005, init 0,
//     no reflection, no final xor)
package dynamixel_pkg;

  localparam logic [7:0]  HDR0            = 8'hFF;
  localparam logic [7:0]  HDR1            = 8'hFF;
  localparam logic [7:0]  HDR2            = 8'hFD;
  localparam logic [7:0]  HDR3            = 8'h00;
  localparam logic [7:0]  BROADCAST_ID    = 8'hFE;
  localparam logic [7:0]  INST_SYNC_WRITE = 8'h83;
  localparam logic [15:0] CRC16_POLY      = 16'h8005;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_DRAIN} state_e;

  // Which part of the frame the byte mux is pointing at.
  typedef enum logic [2:0] {PH_FIX, PH_DATA, PH_CRCL, PH_CRCH, PH_END} phase_e;

  function automatic logic [15:0] crc16_update(input logic [7:0]  b,
                                               input logic [15:0] crc);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dynamixel_crc16.sv
// Registered CRC-16/BUYPASS accumulator, reusable by any frame builder.
//   clock  in   system clock
//   clear  in   synchronous clear to 0x0000 (has priority over en)
//   en     in   fold data into the running CRC
//   data   in   byte to fold
//   crc    out  current CRC value
module dynamixel_crc16
  import dynamixel_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clock) begin
    if (clear)   crc_q <= '0;
    else if (en) crc_q <= crc16_update(data, crc_q);
  end

  assign crc = crc_q;

endmodule

// File: rtl/uart.sv
// Existing 8N1 UART transmitter (no reset; all-zero state is idle).
//   clock  in   system clock
//   send   in   load data and start a character when done==1
//   data   in   8-bit character, sent LSB first
//   done   out  1 while idle / ready for the next character
//   pin    out  TX line, idle high
module uart #(
  parameter int clocks_per_bit = 1
) (
  input  logic       clock,
  input  logic       send,
  input  logic [7:0] data,
  output logic       done,
  output logic       pin
);

  localparam int CW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;

  logic [3:0]    bits_q;
  logic [CW-1:0] tick_q;
  logic [9:0]    shift_q;

  always_ff @(posedge clock) begin
    if (bits_q == 4'd0) begin
      tick_q <= '0;
      if (send) begin
        bits_q  <= 4'd10;
        shift_q <= {1'b1, data, 1'b0};
      end
    end else if (tick_q == CW'(clocks_per_bit - 1)) begin
      tick_q  <= '0;
      bits_q  <= bits_q - 4'd1;
      shift_q <= {1'b1, shift_q[9:1]};
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  assign done = (bits_q == 4'd0);
  assign pin  = done | shift_q[0];

endmodule

// File: rtl/dynamixel_sync_write.sv
// Dynamixel Protocol 2.0 Sync Write (0x83) frame generator for CHANNELS servos.
//   clock       in   system clock
//   reset       in   synchronous, active-high
//   send        in   frame request, accepted only while idle
//   data        in   channel k at [k*DATA_BYTES*8 +: DATA_BYTES*8], sent LSB first
//   busy        out  frame in progress
//   frame_done  out  1-cycle pulse once the last CRC byte has left the uart
//   pin         out  uart TX line, idle high
//   tx_enable   out  half-duplex driver enable (only with DYNAMIXEL_TX_ENABLE_EN)
// Optional feature macro: DYNAMIXEL_TX_ENABLE_EN.
module dynamixel_sync_write
  import dynamixel_pkg::*;
#(
  parameter int clocks_per_bit = 1,
  parameter int CHANNELS       = 4,
  parameter int DATA_BYTES     = 4,
  parameter int ADDRESS        = 116,
  parameter int FIRST_ID       = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           send,
  input  logic [CHANNELS*DATA_BYTES*8-1:0] data,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           pin
`ifdef DYNAMIXEL_TX_ENABLE_EN
  ,
  output logic                           tx_enable
`endif
);

  localparam int          NB     = CHANNELS * DATA_BYTES;
  localparam int          LEN    = 7 + CHANNELS * (1 + DATA_BYTES);
  localparam logic [15:0] LEN16  = 16'(LEN);
  localparam logic [15:0] ADDR16 = 16'(ADDRESS);

  if (CHANNELS < 1 || CHANNELS > 32 || DATA_BYTES < 1 || DATA_BYTES > 4 ||
      ADDRESS < 0 || ADDRESS > 65535 || FIRST_ID < 0 ||
      FIRST_ID + CHANNELS - 1 > 252 || LEN > 65535) begin : g_param_check
    $error("dynamixel_sync_write: parameter out of range");
  end

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [3:0]      idx_q, idx_d;
  logic [4:0]      slot_q, slot_d;
  logic [2:0]      bis_q, bis_d;
  logic            send_q, send_d;
  logic            done_q, done_d;
  logic [NB*8-1:0] shadow_q;
  logic [7:0]      byte_q;
  logic [7:0]      cur_byte;
  logic [15:0]     crc;
  logic            uart_done;
  logic            accept, issue;
  int              bsel;

  // A request landing on the frame_done cycle is dropped.
  assign accept = (state_q == S_IDLE) && send && !done_q;
  assign issue  = (state_q == S_ISSUE) && uart_done;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    bis_d   = bis_q;
    send_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          phase_d = PH_FIX;
          idx_d   = '0;
          slot_d  = '0;
          bis_d   = '0;
        end
      end
      S_ISSUE: begin
        if (uart_done) begin
          send_d  = 1'b1;
          state_d = S_GUARD;
          case (phase_q)
            PH_FIX: begin
              if (idx_q == 4'd11) phase_d = PH_DATA;
              else                idx_d   = idx_q + 4'd1;
            end
            PH_DATA: begin
              if (bis_q == 3'(DATA_BYTES)) begin
                bis_d = '0;
                if (slot_q == 5'(CHANNELS - 1)) phase_d = PH_CRCL;
                else                            slot_d  = slot_q + 5'd1;
              end else begin
                bis_d = bis_q + 3'd1;
              end
            end
            PH_CRCL: phase_d = PH_CRCH;
            PH_CRCH: phase_d = PH_END;
            default: phase_d = PH_END;
          endcase
        end
      end
      // The uart only drops done the cycle after it samples send, so skip one cycle.
      S_GUARD: state_d = (phase_q == PH_END) ? S_DRAIN : S_ISSUE;
      S_DRAIN: begin
        if (uart_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_byte = 8'h00;
    bsel     = int'(slot_q) * DATA_BYTES + int'(bis_q) - 1;
    case (phase_q)
      PH_FIX: begin
        case (idx_q)
          4'd0:    cur_byte = HDR0;
          4'd1:    cur_byte = HDR1;
          4'd2:    cur_byte = HDR2;
          4'd3:    cur_byte = HDR3;
          4'd4:    cur_byte = BROADCAST_ID;
          4'd5:    cur_byte = LEN16[7:0];
          4'd6:    cur_byte = LEN16[15:8];
          4'd7:    cur_byte = INST_SYNC_WRITE;
          4'd8:    cur_byte = ADDR16[7:0];
          4'd9:    cur_byte = ADDR16[15:8];
          4'd10:   cur_byte = 8'(DATA_BYTES);
          default: cur_byte = 8'h00;
        endcase
      end
      PH_DATA: begin
        if (bis_q == 3'd0) begin
          cur_byte = 8'(FIRST_ID) + {3'b000, slot_q};
        end else begin
          for (int k = 0; k < NB; k++) begin
            if (bsel == k) cur_byte = shadow_q[k*8 +: 8];
          end
        end
      end
      PH_CRCL: cur_byte = crc[7:0];
      PH_CRCH: cur_byte = crc[15:8];
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= PH_FIX;
      idx_q   <= '0;
      slot_q  <= '0;
      bis_q   <= '0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      bis_q   <= bis_d;
      send_q  <= send_d;
      done_q  <= done_d;
    end
  end

  // Byte is captured at issue because the counters move on in the same cycle.
  always_ff @(posedge clock) begin
    if (accept) shadow_q <= data;
    if (issue)  byte_q   <= cur_byte;
  end

  dynamixel_crc16 u_crc (
    .clock (clock),
    .clear (reset || accept || (state_q == S_DRAIN && uart_done)),
    .en    (issue && (phase_q == PH_FIX || phase_q == PH_DATA)),
    .data  (cur_byte),
    .crc   (crc)
  );

  uart #(.clocks_per_bit(clocks_per_bit)) u_uart (
    .clock (clock),
    .send  (send_q),
    .data  (byte_q),
    .done  (uart_done),
    .pin   (pin)
  );

`ifdef DYNAMIXEL_TX_ENABLE_EN
  logic txen_q, txen_d;

  // Set together with the uart strobe, released the cycle after frame_done.
  always_comb begin
    txen_d = txen_q;
    if (issue)  txen_d = 1'b1;
    if (done_q) txen_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) txen_q <= 1'b0;
    else       txen_q <= txen_d;
  end

  assign tx_enable = txen_q;
`endif

  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_dynamixel_sync_write.sv
module tb_dynamixel_sync_write;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, send_a, send_b;
  logic [127:0] data_a;
  logic [15:0]  data_b;
  logic         busy_a, fd_a, pin_a, busy_b, fd_b, pin_b;
  logic         crc_clr, crc_en;
  logic [7:0]   crc_din;
  logic [15:0]  crc_out;
`ifdef DYNAMIXEL_TX_ENABLE_EN
  logic         txen_a, txen_b;
`endif

  int checks = 0;
  int errors = 0;

  dynamixel_sync_write dut_a (
    .clock(clk), .reset(rst), .send(send_a), .data(data_a),
    .busy(busy_a), .frame_done(fd_a), .pin(pin_a)
`ifdef DYNAMIXEL_TX_ENABLE_EN
    , .tx_enable(txen_a)
`endif
  );

  dynamixel_sync_write #(
    .clocks_per_bit(1), .CHANNELS(1), .DATA_BYTES(2), .ADDRESS(16'h0040), .FIRST_ID(7)
  ) dut_b (
    .clock(clk), .reset(rst), .send(send_b), .data(data_b),
    .busy(busy_b), .frame_done(fd_b), .pin(pin_b)
`ifdef DYNAMIXEL_TX_ENABLE_EN
    , .tx_enable(txen_b)
`endif
  );

  dynamixel_crc16 u_crc (
    .clock(clk), .clear(crc_clr), .en(crc_en), .data(crc_din), .crc(crc_out)
  );

  // Serial receivers (1 clock per bit), sampled on the falling edge.
  logic [7:0] rxa[$], rxb[$];
  logic [7:0] rsh_a, rsh_b;
  int rbit_a = 0, rbit_b = 0, ferr_a = 0, ferr_b = 0, fda_cnt = 0;

  always @(negedge clk) begin
    if (rbit_a == 0) begin
      if (!pin_a) rbit_a <= 1;
    end else if (rbit_a <= 8) begin
      rsh_a  <= {pin_a, rsh_a[7:1]};
      rbit_a <= rbit_a + 1;
    end else begin
      rxa.push_back(rsh_a);
      if (!pin_a) ferr_a <= ferr_a + 1;
      rbit_a <= 0;
    end
    if (fd_a) fda_cnt <= fda_cnt + 1;
  end

  always @(negedge clk) begin
    if (rbit_b == 0) begin
      if (!pin_b) rbit_b <= 1;
    end else if (rbit_b <= 8) begin
      rsh_b  <= {pin_b, rsh_b[7:1]};
      rbit_b <= rbit_b + 1;
    end else begin
      rxb.push_back(rsh_b);
      if (!pin_b) ferr_b <= ferr_b + 1;
      rbit_b <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC-16/BUYPASS.
  function automatic logic [15:0] model_crc(input logic [7:0] q[$]);
    logic [15:0] c;
    logic fb;
    c = 16'h0000;
    foreach (q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ q[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  task automatic add_crc(inout logic [7:0] e[$]);
    logic [15:0] c;
    c = model_crc(e);
    e.push_back(c[7:0]);
    e.push_back(c[15:8]);
  endtask

  task automatic build_a(input logic [127:0] d, output logic [7:0] e[$]);
    e = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'hFE, 8'h1B, 8'h00, 8'h83, 8'h74, 8'h00, 8'h04, 8'h00};
    for (int ch = 0; ch < 4; ch++) begin
      e.push_back(8'(2 + ch));
      for (int b = 0; b < 4; b++) e.push_back(d[ch*32 + b*8 +: 8]);
    end
    add_crc(e);
  endtask

  task automatic cmp_frame(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
  endtask

  task automatic wait_fd(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 0) ? fd_a : fd_b) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check((which == 0) ? "fd_a_seen" : "fd_b_seen", (which == 0) ? fd_a : fd_b, 1);
  endtask

  initial begin
    logic [71:0]  str;
    logic [7:0]   exp_a[$], exp_b[$], exp_bb[$];
    logic [127:0] d_latched;
    int n, n1, fd0;

    rst = 1'b1; send_a = 1'b0; send_b = 1'b0; data_a = '0; data_b = '0;
    crc_clr = 1'b1; crc_en = 1'b0; crc_din = 8'h00;
    repeat (20) @(negedge clk);
    check("rst_busy_a", busy_a, 0);
    check("rst_fd_a", fd_a, 0);
    check("rst_pin_a", pin_a, 1);
    check("rst_busy_b", busy_b, 0);
`ifdef DYNAMIXEL_TX_ENABLE_EN
    check("rst_txen_a", txen_a, 0);
`endif
    rst = 1'b0;
    crc_clr = 1'b0;
    @(negedge clk);
    check("crc_clear", crc_out, 16'h0000);

    // CRC unit against the standard check string
    str = "123456789";
    for (int i = 0; i < 9; i++) begin
      crc_din = str[71 - 8*i -: 8];
      crc_en  = 1'b1;
      @(negedge clk);
    end
    crc_en = 1'b0;
    check("crc_check", crc_out, 16'hFEE8);

    // Default frame, with start-latency and tx_enable timing
    data_a = {32'h00000000, 32'hFFFFF800, 32'h00000400, 32'h00000800};
    build_a(data_a, exp_a);
    rxa.delete();
    send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
    check("acc_busy", busy_a, 1);
`ifdef DYNAMIXEL_TX_ENABLE_EN
    check("txen_acc", txen_a, 0);
`endif
    @(negedge clk);
    check("pin_pre_start", pin_a, 1);
`ifdef DYNAMIXEL_TX_ENABLE_EN
    check("txen_rise", txen_a, 1);
`endif
    @(negedge clk);
    check("pin_start", pin_a, 0);
    wait_fd(0, 1200);
    check("fd_busy", busy_a, 0);
`ifdef DYNAMIXEL_TX_ENABLE_EN
    check("txen_at_fd", txen_a, 1);
`endif
    cmp_frame("frm2", rxa, exp_a);
    @(negedge clk);
    check("fd_pulse_len", fd_a, 0);
`ifdef DYNAMIXEL_TX_ENABLE_EN
    check("txen_fall", txen_a, 0);
`endif

    // Repeated send and changing data during a frame
    repeat (3) @(negedge clk);
    d_latched = {32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 32'h5A5AA5A5};
    data_a = d_latched;
    build_a(d_latched, exp_a);
    rxa.delete();
    fd0 = fda_cnt;
    send_a = 1'b1;
    @(negedge clk);
    n = 0;
    while (fd_a !== 1'b1 && n < 1200) begin
      data_a = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n++;
    end
    check("fd4_seen", fd_a, 1);
    @(negedge clk);
    send_a = 1'b0;
    check("b2b_ignored", busy_a, 0);
    repeat (40) @(negedge clk);
    cmp_frame("frm4", rxa, exp_a);
    check("fd4_count", fda_cnt - fd0, 1);

    // Reset in the middle of a frame
    data_a = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    rxa.delete();
    send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
    n = 0;
    while (rxa.size() < 20 && n < 800) begin
      @(negedge clk);
      n++;
    end
    check("rst5_reach20", (rxa.size() >= 20), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst5_busy", busy_a, 0);
    check("rst5_fd", fd_a, 0);
`ifdef DYNAMIXEL_TX_ENABLE_EN
    check("rst5_txen", txen_a, 0);
`endif
    repeat (30) @(negedge clk);
    n1 = rxa.size();
    check("rst5_tail", (n1 == 20 || n1 == 21), 1);
    check("rst5_pin_idle", pin_a, 1);
    repeat (40) @(negedge clk);
    check("rst5_no_more", rxa.size(), n1);
    data_a = {32'hCAFEF00D, 32'h00FF00FF, 32'h7FFFFFFF, 32'h80000001};
    build_a(data_a, exp_a);
    rxa.delete();
    send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
    wait_fd(0, 1200);
    cmp_frame("frm5", rxa, exp_a);

    // Small configuration, send held high across two frames
    data_b = 16'h0001;
    exp_b = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'hFE, 8'h0A, 8'h00, 8'h83,
              8'h40, 8'h00, 8'h02, 8'h00, 8'h07, 8'h01, 8'h00};
    add_crc(exp_b);
    rxb.delete();
    send_b = 1'b1;
    @(negedge clk);
    wait_fd(1, 600);
    check("b_fd_busy", busy_b, 0);
    cmp_frame("frm3", rxb, exp_b);
    @(negedge clk);
    check("b_blocked_busy", busy_b, 0);
    check("b_fd_low", fd_b, 0);
    @(negedge clk);
    check("b_next_accept", busy_b, 1);
    send_b = 1'b0;
    wait_fd(1, 600);
    exp_bb = {exp_b, exp_b};
    cmp_frame("frm3x2", rxb, exp_bb);

    check("stopbits_a", ferr_a, 0);
    check("stopbits_b", ferr_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
